// File: rtl/imem_debug_loader_pkg.sv
// Shared constants for the debug/boot loader: state encoding, UART command bytes, halt word.
// Imported by the loader top and its word assembler.
package imem_debug_loader_pkg;

  localparam int LEN_DATA  = 32;
  localparam int RAM_DEPTH = 2048;
  localparam int ADDR_W    = $clog2(RAM_DEPTH);

  localparam logic [LEN_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_CONT  = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_NEXT  = 8'h4E;
  localparam logic [7:0] CMD_REARM = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_WAIT_MODE = 3'd3,
    ST_RUN       = 3'd4,
    ST_STEP_WAIT = 3'd5,
    ST_STEP_RUN  = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

endpackage

// File: rtl/imem_debug_loader_word_assembler.sv
// Big-endian 8->32 assembler: first accepted byte lands in the MSB.
// word_ready is combinational and marks the byte that completes a word.
module imem_debug_loader_word_assembler
  import imem_debug_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic [LEN_DATA-1:0] word,
  output logic                word_ready
);

  logic [1:0] byte_cnt;
  logic       take;

  assign take       = enable && byte_valid;
  assign word_ready = take && (byte_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (take) begin
      word     <= {word[LEN_DATA-9:0], byte_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_debug_loader.sv
// Boot/debug sequencer: loads instruction words from UART into imem, then
// releases the fetch pipeline in continuous or single-step mode.
module imem_debug_loader
  import imem_debug_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done,
  input  logic [7:0]          rx_data,
  input  logic                in_halt_flag,
  output logic [LEN_DATA-1:0] out_ins_to_mem,
  output logic [LEN_DATA-1:0] out_addr_debug,
  output logic                out_wea_ram_inst,
  output logic                out_debug_flag,
  output logic                out_stall_flag,
  output logic                out_pipe_reset,
  output logic                out_load_overflow,
  output logic [2:0]          out_state
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic                overflow;
  logic                pipe_reset;
  logic [LEN_DATA-1:0] word;
  logic                word_ready;
  logic                is_halt_word;
  logic                at_last_addr;
  logic                load_cont;
  logic                load_start;
  logic                assemble_en;

  assign is_halt_word = (word == HALT_WORD);
  assign at_last_addr = (addr == ADDR_W'(RAM_DEPTH - 1));
  // A WRITE that keeps loading also lets its concurrent byte start the next word.
  assign load_cont    = (state == ST_WRITE) && !is_halt_word && !at_last_addr;
  assign assemble_en  = (state == ST_LOAD) || load_cont;
  assign load_start   = rx_done && (rx_data == CMD_LOAD) &&
                        ((state == ST_IDLE) || (state == ST_WAIT_MODE) || (state == ST_DONE));

  imem_debug_loader_word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (reset),
    .clear      (load_start),
    .enable     (assemble_en),
    .byte_valid (rx_done),
    .byte_data  (rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (load_start) state_nxt = ST_LOAD;
      ST_LOAD:      if (word_ready) state_nxt = ST_WRITE;
      ST_WRITE:     state_nxt = load_cont ? ST_LOAD : ST_WAIT_MODE;
      ST_WAIT_MODE: begin
        if (rx_done) begin
          case (rx_data)
            CMD_CONT: state_nxt = ST_RUN;
            CMD_STEP: state_nxt = ST_STEP_WAIT;
            CMD_LOAD: state_nxt = ST_LOAD;
            default:  state_nxt = ST_WAIT_MODE;
          endcase
        end
      end
      ST_RUN:       if (in_halt_flag) state_nxt = ST_DONE;
      // Halt wins over a concurrent 'N'.
      ST_STEP_WAIT: begin
        if (in_halt_flag)                          state_nxt = ST_DONE;
        else if (rx_done && (rx_data == CMD_NEXT)) state_nxt = ST_STEP_RUN;
      end
      ST_STEP_RUN:  state_nxt = in_halt_flag ? ST_DONE : ST_STEP_WAIT;
      ST_DONE: begin
        if (rx_done && (rx_data == CMD_REARM)) state_nxt = ST_IDLE;
        else if (load_start)                   state_nxt = ST_LOAD;
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      overflow   <= 1'b0;
      pipe_reset <= 1'b0;
    end else begin
      state      <= state_nxt;
      pipe_reset <= (state == ST_WRITE) && !load_cont;
      if (load_start) begin
        addr     <= '0;
        overflow <= 1'b0;
      end else if (load_cont) begin
        addr     <= addr + ADDR_W'(1);
      end else if ((state == ST_WRITE) && !is_halt_word) begin
        overflow <= 1'b1;
      end
    end
  end

  assign out_ins_to_mem    = word;
  assign out_addr_debug    = {{(LEN_DATA - ADDR_W){1'b0}}, addr};
  assign out_wea_ram_inst  = (state == ST_WRITE);
  assign out_debug_flag    = (state == ST_STEP_WAIT) || (state == ST_STEP_RUN);
  assign out_stall_flag    = !((state == ST_RUN) || (state == ST_STEP_RUN));
  assign out_pipe_reset    = pipe_reset;
  assign out_load_overflow = overflow;
  assign out_state         = state;

endmodule

// File: tb/tb_imem_debug_loader.sv
// Randomized bench for imem_debug_loader; expected writes/counts come from a
// word-list model of the load rules and cycle counts of the run/step modes.
`timescale 1ns/1ps
module tb_imem_debug_loader;
  import imem_debug_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        in_halt_flag = 1'b0;
  logic [31:0] out_ins_to_mem, out_addr_debug;
  logic        out_wea_ram_inst, out_debug_flag, out_stall_flag;
  logic        out_pipe_reset, out_load_overflow;
  logic [2:0]  out_state;

  always #5 clk = ~clk;

  imem_debug_loader dut (
    .clk               (clk),
    .reset             (reset),
    .rx_done           (rx_done),
    .rx_data           (rx_data),
    .in_halt_flag      (in_halt_flag),
    .out_ins_to_mem    (out_ins_to_mem),
    .out_addr_debug    (out_addr_debug),
    .out_wea_ram_inst  (out_wea_ram_inst),
    .out_debug_flag    (out_debug_flag),
    .out_stall_flag    (out_stall_flag),
    .out_pipe_reset    (out_pipe_reset),
    .out_load_overflow (out_load_overflow),
    .out_state         (out_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Free-running observations; the stimulus side only snapshots them.
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int pipe_reset_cnt = 0;
  int stall_low_cnt  = 0;
  int debug_low_cnt  = 0;
  int wea_run        = 0;
  int max_wea_run    = 0;

  always @(negedge clk) begin
    if (out_wea_ram_inst) begin
      obs_addr.push_back(out_addr_debug);
      obs_data.push_back(out_ins_to_mem);
      wea_run = wea_run + 1;
      if (wea_run > max_wea_run) max_wea_run = wea_run;
    end else begin
      wea_run = 0;
    end
    if (out_pipe_reset)  pipe_reset_cnt = pipe_reset_cnt + 1;
    if (!out_stall_flag) stall_low_cnt  = stall_low_cnt + 1;
    if (!out_debug_flag) debug_low_cnt  = debug_low_cnt + 1;
  end

  logic [31:0] ld_words[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (out_state !== st && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(out_state), 32'(st));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h0;
    return w;
  endfunction

  // Load rule: words go to consecutive addresses from 0; the halt word ends the
  // load (and is written); otherwise the word at the last address ends it with overflow.
  task automatic build_expect();
    exp_addr.delete();
    exp_data.delete();
    exp_ovf = 1'b0;
    foreach (ld_words[i]) begin
      exp_addr.push_back(32'(i));
      exp_data.push_back(ld_words[i]);
      if (ld_words[i] == 32'hFFFF_FFFF) break;
      if (i == RAM_DEPTH - 1) begin
        exp_ovf = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_load(input int gap_max, input string tag);
    int base_w, base_pr, n_obs;
    logic [31:0] w;
    build_expect();
    base_w  = obs_addr.size();
    base_pr = pipe_reset_cnt;
    send_byte(CMD_LOAD);
    idle($urandom_range(0, gap_max));
    foreach (ld_words[i]) begin
      w = ld_words[i];
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[8*b +: 8]);
        idle($urandom_range(0, gap_max));
      end
    end
    wait_state(ST_WAIT_MODE, 20, {tag, "_end_state"});
    tick();
    n_obs = obs_addr.size() - base_w;
    chk({tag, "_n_writes"}, 32'(n_obs), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < n_obs; i++) begin
      chk({tag, "_addr"}, obs_addr[base_w + i], exp_addr[i]);
      chk({tag, "_data"}, obs_data[base_w + i], exp_data[i]);
    end
    chk({tag, "_pipe_reset"}, 32'(pipe_reset_cnt - base_pr), 32'd1);
    chk({tag, "_overflow"}, 32'(out_load_overflow), 32'(exp_ovf));
    chk({tag, "_stall"}, 32'(out_stall_flag), 32'd1);
  endtask

  // Pipeline runs from the cycle after 'C' up to and including the halt cycle.
  task automatic run_cont(input int n);
    int s0;
    send_byte(CMD_CONT);
    chk("cont_state", 32'(out_state), 32'(ST_RUN));
    s0 = stall_low_cnt;
    repeat (n) send_byte(8'($urandom_range(0, 255)));
    in_halt_flag = 1'b1;
    rx_data = CMD_LOAD;
    rx_done = 1'($urandom_range(0, 1));
    tick();
    in_halt_flag = 1'b0;
    rx_done = 1'b0;
    chk("cont_stall_cycles", 32'(stall_low_cnt - s0), 32'(n + 1));
    chk("cont_done_state", 32'(out_state), 32'(ST_DONE));
    chk("cont_done_stall", 32'(out_stall_flag), 32'd1);
  endtask

  // Each 'N' accepted in STEP_WAIT gives exactly one unstalled cycle.
  task automatic run_step(input int k);
    int s0, d0;
    send_byte(CMD_STEP);
    chk("step_state", 32'(out_state), 32'(ST_STEP_WAIT));
    chk("step_debug", 32'(out_debug_flag), 32'd1);
    s0 = stall_low_cnt;
    d0 = debug_low_cnt;
    repeat (k) begin
      idle($urandom_range(1, 3));
      send_byte(CMD_NEXT);
    end
    idle(2);
    chk("step_stall_cycles", 32'(stall_low_cnt - s0), 32'(k));
    chk("step_debug_held", 32'(debug_low_cnt - d0), 32'd0);
    chk("step_back_wait", 32'(out_state), 32'(ST_STEP_WAIT));
    in_halt_flag = 1'b1;
    rx_data = CMD_NEXT;
    rx_done = 1'b1;
    tick();
    in_halt_flag = 1'b0;
    rx_done = 1'b0;
    chk("step_halt_done", 32'(out_state), 32'(ST_DONE));
    idle(1);
    chk("step_halt_no_run", 32'(stall_low_cnt - s0), 32'(k));
  endtask

  task automatic rand_program();
    int n = $urandom_range(1, 6);
    ld_words.delete();
    repeat (n) ld_words.push_back(rand_word());
    ld_words.push_back(32'hFFFF_FFFF);
  endtask

  initial begin
    int base_w;
    logic [7:0] junk;

    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(out_state), 32'(ST_IDLE));
    chk("rst_stall", 32'(out_stall_flag), 32'd1);
    chk("rst_wea", 32'(out_wea_ram_inst), 32'd0);
    chk("rst_debug", 32'(out_debug_flag), 32'd0);
    chk("rst_pipe_reset", 32'(out_pipe_reset), 32'd0);
    chk("rst_overflow", 32'(out_load_overflow), 32'd0);
    chk("rst_addr", out_addr_debug, 32'd0);
    chk("rst_ins", out_ins_to_mem, 32'd0);
    tick();
    reset = 1'b0;
    idle(2);

    // Basic load, continuous run, reload from DONE, step mode, rearm.
    ld_words = '{32'h0000_002A, 32'hFFFF_FFFF};
    run_load(2, "basic");
    run_cont(10);
    run_load(1, "reload");
    run_step(3);
    send_byte(CMD_REARM);
    chk("rearm_idle", 32'(out_state), 32'(ST_IDLE));

    // Random programs and modes.
    for (int r = 0; r < 6; r++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == CMD_LOAD) junk = 8'h00;
      if (out_state == ST_IDLE) begin
        send_byte(junk);
        chk("idle_ignore", 32'(out_state), 32'(ST_IDLE));
      end
      rand_program();
      run_load(3, "rand");
      if ($urandom_range(0, 1) == 1) run_cont($urandom_range(0, 12));
      else                           run_step($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        send_byte(CMD_REARM);
        chk("rand_rearm", 32'(out_state), 32'(ST_IDLE));
      end
    end

    // Back-to-back bytes, including the byte that lands in the WRITE cycle.
    do_reset();
    ld_words = '{32'h1122_3344, 32'h5566_7788, 32'hFFFF_FFFF};
    run_load(0, "b2b");

    // Reset mid-word abandons the partial bytes.
    do_reset();
    send_byte(CMD_LOAD);
    send_byte(8'hAB);
    send_byte(8'hCD);
    do_reset();
    chk("midload_rst_state", 32'(out_state), 32'(ST_IDLE));
    ld_words = '{rand_word(), 32'hFFFF_FFFF};
    run_load(1, "postrst");

    // Fill the whole memory with non-halt words: load ends on the last address.
    ld_words.delete();
    for (int i = 0; i < RAM_DEPTH; i++) ld_words.push_back(rand_word());
    run_load(1, "full");
    chk("full_last_addr", obs_addr[obs_addr.size() - 1], 32'(RAM_DEPTH - 1));
    base_w = obs_addr.size();
    repeat (4) send_byte(8'h00);
    idle(2);
    chk("full_no_extra_writes", 32'(obs_addr.size() - base_w), 32'd0);
    chk("full_stay_wait", 32'(out_state), 32'(ST_WAIT_MODE));

    chk("wea_pulse_width", 32'(max_wea_run), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_debug_loader.md
Name: imem_debug_loader

Overview:
- Debug/boot controller that sequences the instruction-fetch datapath.
- Receives a byte stream from the UART receiver and assembles 32-bit instruction words. Writes them into instruction memory through the debug write port (address, data, write enable).
- Then releases the pipeline, either in continuous mode or single-step mode, and holds it stalled otherwise.
- Sits between the UART RX block and the IF/ID stage stall, write and debug inputs.

Parameters:
- len_data, 32, instruction/data width (fixed 32; byte assembly assumes 4 bytes).
- ram_depth, 2048, instruction memory depth in words; load address range 0..ram_depth-1.
- halt_word, 32'hFFFF_FFFF, instruction encoding that terminates a load and marks program end.
- cmd_load, 8'h4C, 'L': start load.
- cmd_cont, 8'h43, 'C': run continuous.
- cmd_step, 8'h53, 'S': enter step mode.
- cmd_next, 8'h4E, 'N': execute one cycle in step mode.
- cmd_rearm, 8'h52, 'R': return to IDLE after program end.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_done  in  1  one-cycle strobe, rx_data valid.
- rx_data  in  8  received byte.
- in_halt_flag  in  1  halt detected by fetch stage (out_halt_flag_if).
- out_ins_to_mem  out  len_data  assembled instruction word.
- out_addr_debug  out  len_data  word address for the memory write.
- out_wea_ram_inst  out  1  instruction memory write enable, one cycle per word.
- out_debug_flag  out  1  high while in step mode (STEP_WAIT or STEP_RUN).
- out_stall_flag  out  1  freezes PC/pipeline; high except in RUN and STEP_RUN.
- out_pipe_reset  out  1  one-cycle pulse on load completion; restarts PC at 0.
- out_load_overflow  out  1  sticky: load ended by address exhaustion, not halt_word.
- out_state  out  3  current FSM state encoding, for LEDs/debug.

Behaviour:
- Reset (async) values:
  - FSM to IDLE; out_stall_flag=1; all other outputs 0; byte counter 0; address 0.
  - Memory contents are not affected. Reset mid-load abandons the partial word.
- States: IDLE, LOAD, WRITE, WAIT_MODE, RUN, STEP_WAIT, STEP_RUN, DONE.
- IDLE:
  - rx_done with cmd_load -> LOAD, address cleared to 0, overflow cleared.
  - Other bytes are ignored.
- LOAD:
  - Each rx_done shifts rx_data into the word, first byte = MSB (big-endian).
  - A 2-bit byte counter wraps 3->0. The 4th byte -> WRITE on the next edge.
- WRITE (exactly 1 cycle):
  - out_wea_ram_inst=1, out_ins_to_mem=assembled word, out_addr_debug=current address.
  - Next state:
    - word==halt_word -> WAIT_MODE.
    - else address==ram_depth-1 -> WAIT_MODE, out_load_overflow=1.
    - else address+1 and back to LOAD.
  - An rx_done arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
  - Bytes arriving after the load terminates are not assembled.
- WRITE->WAIT_MODE transition: out_pipe_reset=1 for the first cycle in WAIT_MODE.
- WAIT_MODE:
  - cmd_cont -> RUN.
  - cmd_step -> STEP_WAIT.
  - cmd_load -> LOAD (reload).
  - Others are ignored.
- RUN:
  - out_stall_flag=0.
  - in_halt_flag=1 -> DONE; stall reasserts on the next cycle.
  - UART bytes are ignored.
- STEP_WAIT:
  - Stalled, out_debug_flag=1.
  - cmd_next -> STEP_RUN.
  - in_halt_flag=1 -> DONE.
- STEP_RUN (exactly 1 cycle): out_stall_flag=0, then -> STEP_WAIT, or DONE if in_halt_flag.
- DONE:
  - Stalled.
  - cmd_rearm -> IDLE.
  - cmd_load -> LOAD.
- Simultaneous in_halt_flag and rx_done: halt has priority; the byte is dropped.
- Address arithmetic: unsigned and zero-extended to len_data. It never wraps; the overflow rule ends the load first.

Decomposition:
- Shared package:
  - State encoding constants (3-bit).
  - Command byte constants.
  - halt_word.
- One natural sub-module: word_assembler. Holds the 8->32 shift register and the 2-bit byte counter; its word_ready pulse is consumed by the FSM.
- The FSM and the address counter stay in the top level.

Test Plan:
1. Reset, send 'L', 00 00 00 2A, FF FF FF FF:
   - Writes 0x0000002A@0, then 0xFFFFFFFF@1, each with a single-cycle wea.
   - Then WAIT_MODE, pipe_reset pulse, overflow=0.
2. After (1), send 'C', assert in_halt_flag 10 cycles later:
   - stall=0 for exactly those cycles.
   - DONE one edge after halt; stall=1.
3. After (1), send 'S', then 'N' three times:
   - debug_flag=1.
   - stall low for exactly 1 cycle per 'N', 3 total.
4. Load 2048 non-halt words (ram_depth=2048):
   - Last write at address 2047, then WAIT_MODE, out_load_overflow=1.
5. Back-to-back bytes, rx_done every cycle including the WRITE cycle:
   - Words 0x11223344, 0x55667788 written intact at 0 and 1.
6. Assert reset after 2 bytes of a word, then send 'L' + 4 bytes:
   - First write carries only the new 4 bytes at address 0.
